// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 4-channel round-robin merge block.
package mux_pkg;
  localparam int NUM_CH     = 4;
  localparam int SEL_W      = 2;
  localparam int DATA_W_DEF = 3;

  // Channel after idx, wrapping 3 -> 0 through the natural 2-bit overflow.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: priority starts at ptr and rotates past the last winner.
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    cand      = ptr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer only moves when the granted word is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = next_idx(grant_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Round-robin 4:1 merge of valid/ready channels into one registered output stage.
module mux_4to1_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic              accept;

  rr_arbiter_4 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Output register frees up when empty or draining this cycle.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign accept   = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_sel_d   = grant_idx;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Bench for mux_4to1_rr: directed vectors plus a random phase, with a queue scoreboard.
module tb_mux_4to1_rr;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    in_valid = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [DW+1:0] q[$];
  logic [DW+1:0] mon_exp;

  logic          m_ov;
  logic [1:0]    m_ptr, m_sel;
  logic [DW-1:0] m_data;
  logic          m_ld;
  int            m_w;
  logic [3:0]    m_rdy;
  int            waitc[4];

  mux_4to1_rr #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [4*DW-1:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #2;
  endtask

  task automatic out_is(input string tag, input logic v, input int sel, input int data);
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_sel"},   out_sel,   sel);
    chk({tag, "_data"},  out_data,  data);
  endtask

  // Reference model: predicts in_ready, tracks the output register, pushes expected words.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      m_ov = 1'b0; m_ptr = '0; m_sel = '0; m_data = '0;
      q.delete();
      for (int i = 0; i < 4; i++) waitc[i] = 0;
    end else begin
      m_ld = !m_ov || out_ready;
      m_w  = -1;
      for (int k = 0; k < 4; k++)
        if (m_w < 0 && in_valid[(int'(m_ptr) + k) % 4]) m_w = (int'(m_ptr) + k) % 4;
      m_rdy = (m_ld && m_w >= 0) ? 4'(1 << m_w) : 4'b0000;
      chk("model_in_ready", in_ready, m_rdy);
      chk("model_out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("model_out_sel", out_sel, m_sel);
        chk("model_out_data", out_data, m_data);
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && (|in_ready) && !in_ready[i]) begin
          waitc[i]++;
          total++;
          if (waitc[i] > 3) begin
            bad++;
            $display("FAIL fairness ch%0d: waited %0d grants, limit 3", i, waitc[i]);
          end
        end else if (!in_valid[i] || in_ready[i]) begin
          waitc[i] = 0;
        end
      end
      if (m_rdy != 4'b0000) begin
        m_data = in_data[m_w*DW +: DW];
        m_sel  = 2'(m_w);
        q.push_back({m_sel, m_data});
        m_ov   = 1'b1;
        m_ptr  = 2'((m_w + 1) % 4);
      end else if (m_ld) begin
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: every drained word must be the oldest outstanding accepted word.
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got sel=%0d data=0x%0h, nothing expected", out_sel, out_data);
      end else begin
        mon_exp = q.pop_front();
        if ({out_sel, out_data} != mon_exp) begin
          bad++;
          $display("FAIL sb_order: got sel=%0d data=0x%0h want sel=%0d data=0x%0h",
                   out_sel, out_data, mon_exp[DW+1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests pending: nothing may be granted.
    rst_n = 1'b0; in_valid = 4'b1111; in_data = 12'hABC; out_ready = 1'b1;
    @(negedge clk); #2;
    out_is("reset", 1'b0, 0, 0);
    chk("reset_in_ready", in_ready, 0);
    in_valid = 4'b0000;
    rst_n = 1'b1;

    // Full rotation with every channel requesting.
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1111, 12'b111_110_101_100, 1'b1);
      chk("rot_in_ready", in_ready, 1 << (k % 4));
      if (k == 0) chk("rot_first_valid", out_valid, 0);
      else        out_is("rot", 1'b1, (k - 1) % 4, 4 + (k - 1) % 4);
    end

    // ptr=2, only ch0/ch1 request: wrap to ch0 then ch1.
    cyc(4'b0011, 12'b111_110_101_100, 1'b1);
    chk("wrap_rdy0", in_ready, 4'b0001);
    out_is("wrap_prev", 1'b1, 1, 3'b101);
    cyc(4'b0011, 12'b111_110_101_100, 1'b1);
    chk("wrap_rdy1", in_ready, 4'b0010);
    out_is("wrap_ch0", 1'b1, 0, 3'b100);

    // Stall with word ch1/011 held.
    cyc(4'b0010, 12'b111_110_011_100, 1'b1);
    chk("pre_stall_rdy", in_ready, 4'b0010);
    out_is("wrap_ch1", 1'b1, 1, 3'b101);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1111, 12'b111_110_011_100, 1'b0);
      chk("stall_rdy", in_ready, 4'b0000);
      out_is("stall", 1'b1, 1, 3'b011);
    end
    cyc(4'b1111, 12'b111_110_011_100, 1'b1);
    chk("unstall_rdy", in_ready, 4'b0100);
    out_is("unstall", 1'b1, 1, 3'b011);
    cyc(4'b0000, 12'b111_110_011_100, 1'b1);
    chk("idle_rdy", in_ready, 4'b0000);
    out_is("drain_ch2", 1'b1, 2, 3'b110);
    cyc(4'b0000, 12'b111_110_011_100, 1'b1);
    out_is("empty_hold", 1'b0, 2, 3'b110);

    // Single requester on ch3.
    cyc(4'b1000, 12'b101_000_000_000, 1'b1);
    chk("single_rdy", in_ready, 4'b1000);
    cyc(4'b0000, 12'b101_000_000_000, 1'b1);
    out_is("single_out", 1'b1, 3, 3'b101);
    cyc(4'b0000, 12'b101_000_000_000, 1'b1);
    chk("single_gone", out_valid, 0);

    // Async reset while stalled, then priority must restart at ch0.
    cyc(4'b0010, 12'b001_010_011_110, 1'b0);
    chk("prerst_rdy", in_ready, 4'b0010);
    cyc(4'b0010, 12'b001_010_011_110, 1'b0);
    out_is("prerst_held", 1'b1, 1, 3'b011);
    rst_n = 1'b0;
    #1;
    out_is("async_rst", 1'b0, 0, 0);
    chk("async_rst_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b0110; out_ready = 1'b1;
    #2;
    chk("postrst_rdy", in_ready, 4'b0010);
    cyc(4'b0000, 12'b001_010_011_110, 1'b1);
    out_is("postrst_out", 1'b1, 1, 3'b011);
    cyc(4'b0000, 12'b001_010_011_110, 1'b1);

    // Random traffic, checked by the model and scoreboard.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in_valid  = 4'($urandom);
      in_data   = 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 4; n++) cyc(4'b0000, 12'h000, 1'b1);
    chk("sb_leftover", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_4to1_rr.md
MUX_4TO1_RR -- requirements
Module: mux_4to1_rr

Interface
REQ-001 Parameter DATA_W, default 3, SHALL set the per-channel data width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-004 in_valid  input  4  SHALL indicate channel i holds a word (bit i = channel i).
REQ-005 in_data  input  4*DATA_W  SHALL carry channel i data in bits [i*DATA_W +: DATA_W] (ch0 [2:0], ch1 [5:3], ch2 [8:6], ch3 [11:9] at default).
REQ-006 in_ready  output  4  SHALL indicate channel i's word is accepted this cycle.
REQ-007 out_valid  output  1  SHALL indicate out_data/out_sel hold a word.
REQ-008 out_data  output  DATA_W  SHALL be the merged data word.
REQ-009 out_sel  output  2  SHALL be the source channel index of out_data.
REQ-010 out_ready  input  1  SHALL indicate the downstream consumer accepts the word.

Function
REQ-011 Transfer on a channel SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge; on the output when out_valid and out_ready are both 1.
REQ-012 The block SHALL contain one output register (data, sel, valid); load_en = !out_valid or out_ready.
REQ-013 At most one in_ready bit SHALL be 1 per cycle; in_ready[i] = load_en and grant[i], combinational from in_valid, pointer and out state.
REQ-014 Arbitration SHALL be round-robin: priority starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ptr+2, ptr+3 mod 4; the first requesting channel wins.
REQ-015 On an accepted input from channel g, ptr SHALL become (g+1) mod 4 (3 wraps to 0); otherwise ptr SHALL hold.
REQ-016 Latency: a word accepted at edge N SHALL appear on out_data/out_sel with out_valid=1 after edge N (one cycle).
REQ-017 Throughput SHALL be one word per cycle while out_ready=1 and any in_valid=1 (simultaneous drain and load).
REQ-018 Stall: while out_valid=1 and out_ready=0, out_data/out_sel/out_valid SHALL hold and in_ready SHALL be 4'b0000.
REQ-019 With load_en=1 and no in_valid, out_valid SHALL become 0 after the edge; out_data/out_sel SHALL hold their last values.
REQ-020 in_ready SHALL NOT depend on in_data; in_valid withdrawal without handshake SHALL be tolerated (no state change).
REQ-021 The output path SHALL be registered; no combinational path from in_* to out_*.

Reset
REQ-022 While rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=4'b0000.
REQ-023 Reset asserted mid-transfer SHALL discard the held word; after deassertion first grant priority SHALL be ch0.
REQ-024 First grant SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-025 Package mux_pkg SHALL hold NUM_CH=4, SEL_W=2 and the default DATA_W constant.
REQ-026 Sub-module rr_arbiter_4 SHALL implement REQ-014/015 (inputs req[3:0], advance, outputs grant[3:0] one-hot, grant_idx[1:0]); mux_4to1_rr SHALL own the output register and handshake.

Verification
REQ-027 Reset, then in_valid=4'b1111, in_data=12'b111_110_101_100, out_ready=1 held -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 100,101,110,111,100.
REQ-028 ptr=2 (after ch1 grant), in_valid=4'b0011 -> ch0 granted first (wrap past ch2/ch3), then ch1; out_sel 0 then 1.
REQ-029 out_valid=1 with out_sel=1 out_data=011, out_ready=0 for 3 cycles with in_valid=4'b1111 -> outputs stable, in_ready=0000 all 3 cycles; out_ready=1 -> next word ch2 loaded same edge as drain.
REQ-030 Single requester in_valid=4'b1000, data 101, out_ready=1 -> in_ready=1000, out_valid=1 out_sel=3 out_data=101 one cycle later; in_valid=0 -> out_valid=0 next cycle.
REQ-031 rst_n pulsed low while out_valid=1 and stalled -> out_valid/out_data/out_sel=0 immediately (asynchronous); after release in_valid=4'b0110 -> ch1 granted first.
REQ-032 Scoreboard over 1000 random cycles (random in_valid, out_ready): every accepted input appears exactly once, in order, with correct out_sel; no channel waits more than 3 grants while requesting.
